config_bus_fifo: RTL and testbench
==================================

Name: config_bus_fifo

Overview:
- Synchronous buffering stage on the slave side of the Config bus.
- Absorbs `w_en`/`write_data` strobes from the bus master into a small circular FIFO.
- Returns buffered words on `r_en` requests via `read_data`, with a one-cycle registered read latency.
- Reports full/empty/occupancy plus sticky overflow/underflow flags, so the master's pacing can be checked against slave capacity.

Parameters:
- DATA_WIDTH, 8, width of `write_data` and `read_data`.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of `count` (derived; not overridden).

Ports:
- clk  input  1  bus clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- w_en  input  1  push request; `write_data` is sampled on the same edge.
- write_data  input  DATA_WIDTH  push data.
- r_en  input  1  pop request.
- read_data  output  DATA_WIDTH  popped word, registered.
- read_valid  output  1  one-cycle pulse; `read_data` is updated this cycle.
- full  output  1  `count == DEPTH`.
- empty  output  1  `count == 0`.
- count  output  CNT_W  current occupancy.
- clr_err  input  1  synchronous pulse that clears the sticky error flags.
- overflow  output  1  sticky; a push was dropped.
- underflow  output  1  sticky; a pop found the FIFO empty.

Behaviour:
- Reset (`rst_n` low, asynchronous):
  - `wr_ptr = rd_ptr = 0`, `count = 0`.
  - `read_data = 0`, `read_valid = 0`, `overflow = 0`, `underflow = 0`.
  - `empty = 1`, `full = 0`.
  - Storage array contents are not reset.
  - Reset mid-operation discards all buffered words; no `read_valid` pulse follows reset.
- Storage and flags:
  - DEPTH x DATA_WIDTH array with circular pointers of width log2(DEPTH); pointers wrap from DEPTH-1 to 0.
  - `full` and `empty` are decoded combinationally from registered `count`.
- Push acceptance: a push is accepted when `w_en` and (`!full` or an accepted pop in the same cycle).
  - Accepted push writes `mem[wr_ptr]` and advances `wr_ptr`.
- Pop acceptance: a pop is accepted when `r_en` and `!empty`.
  - Next edge: `read_data <= mem[rd_ptr]`, `read_valid <= 1`, `rd_ptr` advances.
  - Otherwise `read_valid <= 0` and `read_data` holds its last value.
- Latency:
  - Push-to-visible: a word pushed at edge N can be popped by an `r_en` sampled at edge N+1 at the earliest.
  - No same-cycle pass-through when empty.
- Simultaneous push and pop:
  - Not full, not empty: both accepted, `count` unchanged.
  - Full: both accepted. The pop reads the oldest word and the push writes the freed slot. `count` stays at DEPTH and `overflow` is not set.
  - Empty: push accepted, pop rejected and `underflow` set; `count` becomes 1.
- Count update: `count` increments on push only, decrements on pop only, and is unchanged on both or neither.
- Errors:
  - `w_en` while full with no accepted pop: word dropped, `overflow <= 1`.
  - `r_en` while empty: `underflow <= 1`.
  - `clr_err` clears both flags. An error event in the same cycle as `clr_err` wins: the flag stays or becomes 1.
  - Errors never change pointers, `count`, or `read_data`.

Optional Feature:
- Macro CONFIG_BUS_FIFO_STATS_EN.
- When defined:
  - Adds output `drop_count`, 8 bits: increments on every dropped push and saturates at 8'hFF.
  - Cleared by reset and by `clr_err`. A drop in the same cycle as `clr_err` loads 1.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle 3 cycles -> `empty = 1`, `full = 0`, `count = 0`, `read_valid = 0`, `read_data = 8'h00`, both error flags 0.
- Push 8'hA1, 8'hA2, 8'hA3, 8'hA4 on consecutive cycles, then pop 4 times -> `full = 1` after the 4th push; `read_data` = A1, A2, A3, A4 each with a single-cycle `read_valid`; `empty = 1` at the end.
- Fill to full, push 8'hFF alone -> `overflow = 1`, `count = 4`, drained data excludes 8'hFF; with CONFIG_BUS_FIFO_STATS_EN, `drop_count = 1`.
- Full, same-cycle push 8'h55 and pop -> `read_data` = oldest word, `count = 4`, `overflow = 0`; 8'h55 emerges last after draining.
- Empty, same-cycle push 8'h33 and pop -> `underflow = 1`, `read_valid = 0`, `count = 1`; next pop returns 8'h33; `clr_err` pulse then clears `underflow`.
- Push 6 and pop 6 interleaved with DEPTH = 4 (pointer wrap), then assert `rst_n` low mid-stream -> data order preserved across the wrap; after reset `count = 0` and no stale `read_valid`.

Source files
------------

// File: rtl/config_bus_fifo.sv
// Config bus slave-side FIFO: circular buffer with registered read port, occupancy and sticky error flags.
// Optional drop counter enabled by defining CONFIG_BUS_FIFO_STATS_EN.
module config_bus_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count,
  input  logic                  clr_err,
`ifdef CONFIG_BUS_FIFO_STATS_EN
  output logic [7:0]            drop_count,
`endif
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_read_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_underrun;
  logic [CNT_W-1:0]      w_count_nxt;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_pop      = r_en && !w_empty;
  // A pop in the same cycle frees the slot the push is about to fill.
  assign w_push     = w_en && (!w_full || w_pop);
  assign w_drop     = w_en && !w_push;
  assign w_underrun = r_en && w_empty;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: storage has no reset; only pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= write_data;
  end

  // NOTE: sequential state uses non-blocking assignments so the full-case read below sees the pre-edge word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_count      <= w_count_nxt;
      r_read_valid <= w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_read_data <= r_mem[r_rd_ptr];
        r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
      end
      // Error events dominate a simultaneous clear.
      r_overflow  <= w_drop     || (r_overflow  && !clr_err);
      r_underflow <= w_underrun || (r_underflow && !clr_err);
    end
  end

`ifdef CONFIG_BUS_FIFO_STATS_EN
  logic [7:0] r_drop_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_count <= '0;
    end else if (clr_err) begin
      r_drop_count <= w_drop ? 8'd1 : 8'd0;
    end else if (w_drop && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign drop_count = r_drop_count;
`endif

  assign read_data  = r_read_data;
  assign read_valid = r_read_valid;
  assign full       = w_full;
  assign empty      = w_empty;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_config_bus_fifo.sv
// Self-checking bench for config_bus_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_config_bus_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            w_en = 1'b0;
  logic [DW-1:0]   write_data = '0;
  logic            r_en = 1'b0;
  logic [DW-1:0]   read_data;
  logic            read_valid;
  logic            full;
  logic            empty;
  logic [CNT_W-1:0] count;
  logic            clr_err = 1'b0;
  logic            overflow;
  logic            underflow;
`ifdef CONFIG_BUS_FIFO_STATS_EN
  logic [7:0]      drop_count;
`endif

  config_bus_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .w_en       (w_en),
    .write_data (write_data),
    .r_en       (r_en),
    .read_data  (read_data),
    .read_valid (read_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .clr_err    (clr_err),
`ifdef CONFIG_BUS_FIFO_STATS_EN
    .drop_count (drop_count),
`endif
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the FIFO as a plain queue plus the observable registers.
  logic [DW-1:0] m_q [$];
  logic [DW-1:0] m_rdata;
  logic          m_rvalid;
  logic          m_ovf;
  logic          m_udf;
  int            m_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_drop   = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},      32'(count),      32'(m_q.size()));
    check({tag, ".empty"},      32'(empty),      32'(m_q.size() == 0));
    check({tag, ".full"},       32'(full),       32'(m_q.size() == DEPTH));
    check({tag, ".read_valid"}, 32'(read_valid), 32'(m_rvalid));
    check({tag, ".read_data"},  32'(read_data),  32'(m_rdata));
    check({tag, ".overflow"},   32'(overflow),   32'(m_ovf));
    check({tag, ".underflow"},  32'(underflow),  32'(m_udf));
`ifdef CONFIG_BUS_FIFO_STATS_EN
    check({tag, ".drop_count"}, 32'(drop_count), 32'(m_drop));
`endif
  endtask

  // One clock: drive inputs, advance the model by the FIFO rules, compare just after the edge.
  task automatic step(input string tag, input logic w, input logic [DW-1:0] d,
                      input logic r, input logic c);
    bit pop_ok, push_ok, drop_ev, udf_ev;
    w_en = w; write_data = d; r_en = r; clr_err = c;
    @(posedge clk);
    #1;
    udf_ev  = r && (m_q.size() == 0);
    pop_ok  = r && (m_q.size() != 0);
    push_ok = w && ((m_q.size() < DEPTH) || pop_ok);
    drop_ev = w && !push_ok;
    m_rvalid = pop_ok;
    if (pop_ok) m_rdata = m_q.pop_front();
    if (push_ok) m_q.push_back(d);
    m_ovf = drop_ev || (m_ovf && !c);
    m_udf = udf_ev  || (m_udf && !c);
    if (c)                           m_drop = drop_ev ? 1 : 0;
    else if (drop_ev && m_drop < 255) m_drop++;
    check_all(tag);
    w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset and idle.
    for (int i = 0; i < 3; i++) step("idle", 1'b0, '0, 1'b0, 1'b0);
    check("idle.read_data_zero", 32'(read_data), 32'h00);
    check("idle.empty_one", 32'(empty), 32'd1);

    // Fill with A1..A4, then drain in order.
    for (int i = 0; i < 4; i++) step("fill", 1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
    check("fill.full_after_4", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step("drain", 1'b0, '0, 1'b1, 1'b0);
      check("drain.word", 32'(read_data), 32'(8'hA1 + 8'(i)));
    end
    step("drain.pulse_end", 1'b0, '0, 1'b0, 1'b0);
    check("drain.valid_single_cycle", 32'(read_valid), 32'd0);

    // Overflow: push FF into a full FIFO.
    for (int i = 0; i < 4; i++) step("ovf.fill", 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    step("ovf.drop", 1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf.flag", 32'(overflow), 32'd1);
    check("ovf.count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step("ovf.drain", 1'b0, '0, 1'b1, 1'b0);
      check("ovf.no_ff", 32'(read_data == 8'hFF), 32'd0);
    end
    step("ovf.clr", 1'b0, '0, 1'b0, 1'b1);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 4; i++) step("both.fill", 1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    step("both.full", 1'b1, 8'h55, 1'b1, 1'b0);
    check("both.oldest", 32'(read_data), 32'h20);
    check("both.no_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) step("both.drain", 1'b0, '0, 1'b1, 1'b0);
    check("both.55_last", 32'(read_data), 32'h55);

    // Empty with simultaneous push and pop.
    step("empty.both", 1'b1, 8'h33, 1'b1, 1'b0);
    check("empty.udf", 32'(underflow), 32'd1);
    check("empty.count1", 32'(count), 32'd1);
    step("empty.pop", 1'b0, '0, 1'b1, 1'b0);
    check("empty.got33", 32'(read_data), 32'h33);
    step("empty.clr", 1'b0, '0, 1'b0, 1'b1);
    check("empty.udf_cleared", 32'(underflow), 32'd0);

    // Interleaved traffic across the pointer wrap, then reset mid-stream.
    for (int i = 0; i < 6; i++) begin
      step("wrap.push", 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
      step("wrap.pop",  1'b0, '0, 1'b1, 1'b0);
      check("wrap.order", 32'(read_data), 32'(8'h60 + 8'(i)));
    end
    step("wrap.p1", 1'b1, 8'h77, 1'b0, 1'b0);
    step("wrap.p2", 1'b1, 8'h78, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("rst.async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("rst.idle", 1'b0, '0, 1'b0, 1'b0);
    check("rst.no_stale_valid", 32'(read_valid), 32'd0);

    // Random traffic in phases biased toward filling, draining and balance.
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 80; i++) begin
        int pw, pr;
        pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
        pr = 100 - pw;
        step("rand", ($urandom_range(99) < pw), DW'($urandom), ($urandom_range(99) < pr),
             ($urandom_range(15) == 0));
      end
    end

`ifdef CONFIG_BUS_FIFO_STATS_EN
    // Saturating drop counter.
    for (int i = 0; i < 4; i++) step("sat.fill", 1'b1, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) step("sat.drop", 1'b1, 8'h02, 1'b0, 1'b0);
    check("sat.ff", 32'(drop_count), 32'hFF);
    step("sat.clr_drop", 1'b1, 8'h03, 1'b0, 1'b1);
    check("sat.clr_loads1", 32'(drop_count), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
